// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the 8:1 mux scan controller.
// No logic; types and sizing constants only.
// Not applicable (no datapath here).
package mux_scan_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int NCH  = 8;
  localparam int SELW = 3;

endpackage

// File: rtl/mod8_sel_counter.sv
// Modulo-8 channel counter driving the mux select lines, with a wrap flag.
// Latency: sel updates one clock after en; wrap is combinational from sel.
// Backpressure: none; it advances only when the controller enables it.
module mod8_sel_counter
  import mux_scan_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [SELW-1:0] sel,
  output logic            wrap
);

  // Counter register: a clear (or reset) wins over an increment; 7 rolls to 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sel <= '0;
    end else if (en) begin
      sel <= sel + 1'b1;
    end
  end

  assign wrap = (sel == SELW'(NCH - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans all eight mux channels, captures Y per channel, and reports the byte.
// Latency: 8*DWELL clocks from start to the valid pulse; no gap in continuous mode.
// Backpressure: none; start is ignored while busy and valid is a single-cycle pulse.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic       Y,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy
);

  // The dwell counter only needs to reach DWELL-1, which is at most 15.
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        dwell;
  logic [NCH-1:0]    shadow;
  logic [NCH-1:0]    frame_byte;
  logic [SELW-1:0]   sel;
  logic              wrap;
  logic              sample;
  logic              frame_end;
  logic              sel_clr;

  // A sample happens on the last dwell cycle of a channel; abort suppresses it
  // so an aborted frame can never publish or advance the selects.
  assign sample    = (state == SCAN) && (dwell == DWELL_LAST) && !abort;
  assign frame_end = sample && wrap;
  assign sel_clr   = (state == SCAN) && abort;

  mod8_sel_counter u_sel (
    .clk  (clk),
    .rst  (rst),
    .en   (sample),
    .clr  (sel_clr),
    .sel  (sel),
    .wrap (wrap)
  );

  assign {S2, S1, S0} = sel;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and busy flag; abort outranks frame end and cont.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (frame_end && !cont) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Published byte: earlier channels from the shadow, the current channel live from Y.
  always_comb begin
    frame_byte      = shadow;
    frame_byte[sel] = Y;
  end

  // Dwell counter: runs only in SCAN, restarting at each channel boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
    end else if ((state != SCAN) || abort || (dwell == DWELL_LAST)) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Capture path: the shadow collects samples, and only a completed frame reaches data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= frame_end;
      if (sample) begin
        shadow[sel] <= Y;
      end
      if (frame_end) begin
        data_out <= frame_byte;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, abort;
  logic [7:0] d;
  logic       y;
  logic       s2, s1, s0;
  logic [7:0] data_out;
  logic       valid, busy;

  logic       start3;
  logic [7:0] d3;
  logic       y3;
  logic       t2, t1, t0;
  logic [7:0] data_out3;
  logic       valid3, busy3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the structural 8:1 mux: Y = D[select].
  assign y  = d[{s2, s1, s0}];
  assign y3 = d3[{t2, t1, t0}];

  mux_scan_ctrl #(.DWELL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort), .Y(y),
    .S2(s2), .S1(s1), .S0(s0), .data_out(data_out), .valid(valid), .busy(busy)
  );

  mux_scan_ctrl #(.DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cont(1'b0), .abort(1'b0), .Y(y3),
    .S2(t2), .S1(t1), .S0(t0), .data_out(data_out3), .valid(valid3), .busy(busy3)
  );

  typedef struct {
    logic       start;
    logic       cont;
    logic       abort;
    logic [7:0] d;
    logic [2:0] esel;
    logic       evalid;
    logic       ebusy;
    logic [7:0] edata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic c, input logic a, input logic [7:0] dv,
                     input logic [2:0] es, input logic ev, input logic eb, input logic [7:0] ed);
    vec_t v;
    v.start = s; v.cont = c; v.abort = a; v.d = dv;
    v.esel = es; v.evalid = ev; v.ebusy = eb; v.edata = ed;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [2:0] es, input logic ev,
                            input logic eb, input logic [7:0] ed);
    check({tag, " sel"},   {5'd0, s2, s1, s0}, {5'd0, es});
    check({tag, " valid"}, {7'd0, valid},      {7'd0, ev});
    check({tag, " busy"},  {7'd0, busy},       {7'd0, eb});
    check({tag, " data"},  data_out,           ed);
  endtask

  task automatic run_dwell3(input logic [7:0] dv);
    d3 = dv; start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("dw3 start sel", {5'd0, t2, t1, t0}, 8'd0);
    check("dw3 start busy", {7'd0, busy3}, 8'd1);
    for (int n = 1; n <= 23; n++) begin
      step();
      check($sformatf("dw3 edge%0d sel", n), {5'd0, t2, t1, t0}, 8'(n / 3));
      check($sformatf("dw3 edge%0d valid", n), {7'd0, valid3}, 8'd0);
    end
    step();
    check("dw3 end valid", {7'd0, valid3}, 8'd1);
    check("dw3 end data", data_out3, dv);
    check("dw3 end busy", {7'd0, busy3}, 8'd0);
    step();
    check("dw3 after valid", {7'd0, valid3}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; d = 8'h00;
    start3 = 1'b0; d3 = 8'h00;

    // Reset state
    step();
    step();
    check_main("reset", 3'd0, 1'b0, 1'b0, 8'h00);
    check("reset dw3 data", data_out3, 8'h00);
    check("reset dw3 busy", {7'd0, busy3}, 8'd0);
    rst = 1'b0;
    step();

    // Single frame, D=A6
    add(1, 0, 0, 8'hA6, 3'd0, 0, 1, 8'h00);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 8'hA6, 3'(k), 0, 1, 8'h00);
    add(0, 0, 0, 8'hA6, 3'd0, 1, 0, 8'hA6);
    add(0, 0, 0, 8'hA6, 3'd0, 0, 0, 8'hA6);
    // Continuous: frame 1 A6, frame 2 takes bits 4..7 from 3C -> 36
    add(1, 1, 0, 8'hA6, 3'd0, 0, 1, 8'hA6);
    for (int k = 1; k <= 7; k++) add(0, 1, 0, 8'hA6, 3'(k), 0, 1, 8'hA6);
    add(0, 1, 0, 8'hA6, 3'd0, 1, 1, 8'hA6);
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 8'hA6, 3'(k), 0, 1, 8'hA6);
    for (int k = 5; k <= 7; k++) add(0, 1, 0, 8'h3C, 3'(k), 0, 1, 8'hA6);
    add(0, 0, 0, 8'h3C, 3'd0, 1, 0, 8'h36);
    add(0, 0, 0, 8'h3C, 3'd0, 0, 0, 8'h36);
    // Frame 5A completes, then abort at sel=4
    add(1, 1, 0, 8'h5A, 3'd0, 0, 1, 8'h36);
    for (int k = 1; k <= 7; k++) add(0, 1, 0, 8'h5A, 3'(k), 0, 1, 8'h36);
    add(0, 1, 0, 8'h5A, 3'd0, 1, 1, 8'h5A);
    for (int k = 1; k <= 4; k++) add(0, 1, 0, 8'h5A, 3'(k), 0, 1, 8'h5A);
    add(0, 1, 1, 8'h5A, 3'd0, 0, 0, 8'h5A);
    add(0, 0, 0, 8'h5A, 3'd0, 0, 0, 8'h5A);
    // Abort in IDLE does nothing
    add(0, 0, 1, 8'h5A, 3'd0, 0, 0, 8'h5A);
    // Abort on the frame-end edge beats the publish
    add(1, 0, 0, 8'hFF, 3'd0, 0, 1, 8'h5A);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 8'hFF, 3'(k), 0, 1, 8'h5A);
    add(0, 1, 1, 8'hFF, 3'd0, 0, 0, 8'h5A);
    add(0, 0, 0, 8'hFF, 3'd0, 0, 0, 8'h5A);
    // start held while busy is ignored: exactly one valid
    add(1, 0, 0, 8'hC3, 3'd0, 0, 1, 8'h5A);
    for (int k = 1; k <= 7; k++) add(1, 0, 0, 8'hC3, 3'(k), 0, 1, 8'h5A);
    add(0, 0, 0, 8'hC3, 3'd0, 1, 0, 8'hC3);
    add(0, 0, 0, 8'hC3, 3'd0, 0, 0, 8'hC3);
    add(0, 0, 0, 8'hC3, 3'd0, 0, 0, 8'hC3);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; cont = tbl[i].cont; abort = tbl[i].abort; d = tbl[i].d;
      step();
      check_main($sformatf("row%0d", i), tbl[i].esel, tbl[i].evalid, tbl[i].ebusy, tbl[i].edata);
    end
    start = 1'b0; cont = 1'b0; abort = 1'b0;

    // Reset mid-frame during continuous scan, then a clean frame
    start = 1'b1; cont = 1'b1; d = 8'hA6;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    check("pre-rst sel", {5'd0, s2, s1, s0}, 8'd5);
    rst = 1'b1;
    step();
    check_main("mid rst", 3'd0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0; cont = 1'b0; d = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    check_main("post-rst sel7", 3'd7, 1'b0, 1'b1, 8'h00);
    step();
    check_main("post-rst end", 3'd0, 1'b1, 1'b0, 8'h3C);

    // DWELL=3 instance
    run_dwell3(8'hFF);
    run_dwell3(8'h2D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
